energy_peak_search: RTL and testbench

Timing-phase search controller that sits directly downstream of the I/Q integrator. It steps an upstream phase selector through NUM_HYP hypotheses and restarts the integrator with a shift_parse pulse at each step. It captures the integrator's window energy on result_ok and tracks the strongest hypothesis. When the sweep finishes it reports the best phase index and energy, plus a lock flag from a threshold compare.

---
 rtl/sync_pkg.sv | 14 +
 rtl/energy_peak_search_if.sv | 29 ++
 rtl/peak_tracker.sv | 46 ++++
 rtl/energy_peak_search.sv | 124 ++++++++++++
 tb/tb_energy_peak_search.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_pkg.sv
// Shared types and constants for the timing-phase search path.
package sync_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StWait,
    StFin
  } state_e;

  localparam int unsigned ENERGY_W  = 20;
  localparam int unsigned INTEG_LEN = 496;

endpackage

// File: rtl/energy_peak_search_if.sv
// Control/result bundle between the host, the integrator and the peak search.
interface energy_peak_search_if #(
  parameter int unsigned HYP_W = 8
) ();
  import sync_pkg::*;

  logic                start;
  logic                abort;
  logic [ENERGY_W-1:0] energy;
  logic                result_ok;
  logic                shift_parse;
  logic [HYP_W-1:0]    hyp_idx;
  logic                busy;
  logic                done;
  logic [HYP_W-1:0]    best_idx;
  logic [ENERGY_W-1:0] best_energy;
  logic                lock;

  modport master (
    output start, abort, energy, result_ok,
    input  shift_parse, hyp_idx, busy, done, best_idx, best_energy, lock
  );

  modport slave (
    input  start, abort, energy, result_ok,
    output shift_parse, hyp_idx, busy, done, best_idx, best_energy, lock
  );

endinterface

// File: rtl/peak_tracker.sv
// Running maximum of (index, value) pairs; strict greater-than so ties keep the earlier index.
module peak_tracker #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned VAL_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             first,
  input  logic [IDX_W-1:0] idx,
  input  logic [VAL_W-1:0] val,
  output logic [IDX_W-1:0] max_idx,
  output logic [VAL_W-1:0] max_val
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] val_q, val_d;

  always_comb begin
    idx_d = idx_q;
    val_d = val_q;
    if (clear) begin
      idx_d = '0;
      val_d = '0;
    end else if (load && (first || (val > val_q))) begin
      idx_d = idx;
      val_d = val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      val_q <= '0;
    end else begin
      idx_q <= idx_d;
      val_q <= val_d;
    end
  end

  // Exposes the max including this cycle's candidate so the final capture can be reported at once.
  assign max_idx = idx_d;
  assign max_val = val_d;

endmodule

// File: rtl/energy_peak_search.sv
// Sweeps phase hypotheses, restarts the integrator per step and reports the strongest one.
module energy_peak_search
  import sync_pkg::*;
#(
  parameter int unsigned         NUM_HYP  = 16,
  parameter int unsigned         HYP_W    = 8,
  parameter int unsigned         SKIP_WIN = 1,
  parameter logic [ENERGY_W-1:0] THRESH   = 20'd4096
) (
  input logic clk,
  input logic rst_n,
  energy_peak_search_if.slave bus
);

  localparam logic [HYP_W-1:0] LastHyp = HYP_W'(NUM_HYP - 1);
  localparam logic [2:0]       SkipWin = 3'(SKIP_WIN);

  state_e              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [HYP_W-1:0]    hyp_q, hyp_d;
  logic                capture, clear;
  logic [HYP_W-1:0]    trk_idx;
  logic [ENERGY_W-1:0] trk_max;

  logic                shift_q, busy_q, done_q, lock_q;
  logic [HYP_W-1:0]    best_idx_q;
  logic [ENERGY_W-1:0] best_energy_q;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    hyp_d   = hyp_q;
    capture = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StShift;
          hyp_d   = '0;
          clear   = 1'b1;
        end
      end
      StShift: begin
        state_d = StWait;
        skip_d  = '0;
      end
      StWait: begin
        if (bus.result_ok) begin
          if (skip_q != SkipWin) begin
            skip_d = skip_q + 3'd1;
          end else begin
            capture = 1'b1;
            if (hyp_q == LastHyp) begin
              state_d = StFin;
            end else begin
              hyp_d   = hyp_q + 1'b1;
              state_d = StShift;
            end
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides everything: no capture, counters frozen.
    if (bus.abort && (state_q != StIdle)) begin
      state_d = StIdle;
      skip_d  = skip_q;
      hyp_d   = hyp_q;
      capture = 1'b0;
      clear   = 1'b0;
    end
  end

  peak_tracker #(
    .IDX_W (HYP_W),
    .VAL_W (ENERGY_W)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .load    (capture),
    .first   (hyp_q == '0),
    .idx     (hyp_q),
    .val     (bus.energy),
    .max_idx (trk_idx),
    .max_val (trk_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      skip_q        <= '0;
      hyp_q         <= '0;
      shift_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      best_idx_q    <= '0;
      best_energy_q <= '0;
      lock_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      hyp_q   <= hyp_d;
      shift_q <= (state_d == StShift);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFin);
      if (state_d == StFin) begin
        best_idx_q    <= trk_idx;
        best_energy_q <= trk_max;
        lock_q        <= (trk_max >= THRESH);
      end
    end
  end

  assign bus.shift_parse = shift_q;
  assign bus.hyp_idx     = hyp_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.best_idx    = best_idx_q;
  assign bus.best_energy = best_energy_q;
  assign bus.lock        = lock_q;

endmodule

// File: tb/tb_energy_peak_search.sv
// Bench for energy_peak_search: behavioural integrator, sweep vector table, done scoreboard.
module tb_energy_peak_search;
  import sync_pkg::*;

  localparam int unsigned WIN  = INTEG_LEN + 1;
  localparam int unsigned PER0 = WIN + 1;
  localparam int unsigned PER1 = 2 * WIN + 1;
  localparam int unsigned NH0  = 16;
  localparam int unsigned NH1  = 8;

  typedef struct {
    bit          flat;
    int          pk;
    logic [19:0] pk_e;
    logic [7:0]  x_idx;
    logic [19:0] x_e;
    bit          x_lock;
  } vec_t;

  typedef struct {
    logic [7:0]  idx;
    logic [19:0] e;
    bit          lk;
    int          at;
  } exp_t;

  logic clk;
  logic rst_n, rst1_n;
  int   cyc;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt0 = 0;
  bit   spur0 = 0;
  bit   fin1 = 0;
  logic [19:0] etab0[NH0];
  logic [19:0] cap1[NH1];
  logic [19:0] disc1[NH1];
  exp_t sb0[$];
  vec_t vecs[6];

  energy_peak_search_if #(.HYP_W(8)) bus0 ();
  energy_peak_search_if #(.HYP_W(8)) bus1 ();

  energy_peak_search #(
    .NUM_HYP (NH0),
    .HYP_W   (8),
    .SKIP_WIN(0),
    .THRESH  (20'd4096)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  energy_peak_search #(
    .NUM_HYP (NH1),
    .HYP_W   (8),
    .SKIP_WIN(1),
    .THRESH  (20'd4096)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst1_n),
    .bus  (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Integrator model for dut0: result_ok WIN cycles after each shift_parse, then every WIN.
  initial begin : integ0
    int cnt;
    bit act, ok;
    logic [7:0] h;
    cnt = 0; act = 0; h = '0;
    bus0.result_ok = 1'b0;
    bus0.energy    = '0;
    forever begin
      @(negedge clk);
      #1;
      ok = 0;
      if (!rst_n) act = 0;
      else if (bus0.shift_parse) begin
        act = 1; cnt = 0; h = bus0.hyp_idx;
      end else if (!bus0.busy) act = 0;
      else if (act) begin
        cnt++;
        if (cnt == WIN) begin
          ok = 1; cnt = 0;
        end
      end
      bus0.result_ok = ok | spur0;
      bus0.energy    = ok ? etab0[h[3:0]] : 20'hFFFFF;
    end
  end

  // Integrator model for dut1; first window after a shift carries the discard energy.
  initial begin : integ1
    int cnt, win;
    bit act, ok;
    logic [7:0] h;
    cnt = 0; win = 0; act = 0; h = '0;
    bus1.result_ok = 1'b0;
    bus1.energy    = '0;
    forever begin
      @(negedge clk);
      #1;
      ok = 0;
      if (!rst1_n) act = 0;
      else if (bus1.shift_parse) begin
        act = 1; cnt = 0; win = 0; h = bus1.hyp_idx;
      end else if (!bus1.busy) act = 0;
      else if (act) begin
        cnt++;
        if (cnt == WIN) begin
          ok = 1; cnt = 0;
        end
      end
      bus1.result_ok = ok;
      bus1.energy    = ok ? ((win == 0) ? disc1[h[2:0]] : cap1[h[2:0]]) : 20'h00000;
      if (ok) win++;
    end
  end

  // dut0 monitor: hypothesis stepping, shift period and done scoreboard.
  initial begin : mon0
    bit prev_busy;
    int last_shift;
    logic [7:0] last_hyp;
    exp_t x;
    prev_busy = 0; last_shift = 0; last_hyp = '0;
    forever begin
      @(negedge clk);
      if (bus0.shift_parse) begin
        if (!prev_busy) check("first_hyp", bus0.hyp_idx, 0);
        else begin
          check("hyp_step", bus0.hyp_idx, longint'(last_hyp) + 1);
          check("shift_period", cyc - last_shift, PER0);
        end
        last_hyp   = bus0.hyp_idx;
        last_shift = cyc;
      end
      if (bus0.done) begin
        done_cnt0++;
        if (sb0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          x = sb0.pop_front();
          check("done_cycle", cyc, x.at);
          check("best_idx", bus0.best_idx, x.idx);
          check("best_energy", bus0.best_energy, x.e);
          check("lock", bus0.lock, x.lk);
        end
      end
      prev_busy = bus0.busy;
    end
  end

  task automatic check_all_zero0(input string tag);
    check({tag, "_shift"}, bus0.shift_parse, 0);
    check({tag, "_hyp"}, bus0.hyp_idx, 0);
    check({tag, "_busy"}, bus0.busy, 0);
    check({tag, "_done"}, bus0.done, 0);
    check({tag, "_bidx"}, bus0.best_idx, 0);
    check({tag, "_benergy"}, bus0.best_energy, 0);
    check({tag, "_lock"}, bus0.lock, 0);
  endtask

  task automatic start0(output int t0);
    @(negedge clk);
    bus0.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  initial begin : main0
    int t0, w, dc;
    exp_t x;
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    rst_n = 1'b0;
    vecs[0] = '{0, 5, 20'd9000, 8'd5, 20'd9000, 1};
    vecs[1] = '{1, 0, 20'd4095, 8'd0, 20'd4095, 0};
    vecs[2] = '{1, 0, 20'd4096, 8'd0, 20'd4096, 1};
    vecs[3] = '{1, 0, 20'd0, 8'd0, 20'd0, 0};
    vecs[4] = '{0, 15, 20'd70000, 8'd15, 20'd70000, 1};
    vecs[5] = '{0, 2, 20'd3000, 8'd2, 20'd3000, 0};
    for (int k = 0; k < NH0; k++) etab0[k] = 20'(100 * k);
    repeat (3) @(negedge clk);
    check_all_zero0("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Spurious result_ok in IDLE must not start anything.
    spur0 = 1;
    repeat (3) @(negedge clk);
    spur0 = 0;
    @(negedge clk);
    check_all_zero0("spur_idle");

    // Reset mid-sweep: outputs clear asynchronously, no done.
    start0(t0);
    dc = done_cnt0;
    while (cyc < t0 + 3000) @(negedge clk);
    check("pre_reset_busy", bus0.busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero0("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_no_done", done_cnt0, dc);

    foreach (vecs[i]) begin
      for (int k = 0; k < NH0; k++)
        etab0[k] = vecs[i].flat ? vecs[i].pk_e : ((k == vecs[i].pk) ? vecs[i].pk_e : 20'(100 * k));
      start0(t0);
      x.idx = vecs[i].x_idx; x.e = vecs[i].x_e; x.lk = vecs[i].x_lock;
      x.at  = t0 + PER0 * NH0 + 1;
      sb0.push_back(x);
      check("sweep_busy", bus0.busy, 1);
      check("sweep_shift0", bus0.shift_parse, 1);
      if (i == 0) begin
        // start while busy must be ignored
        while (cyc < t0 + 600) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
      end
      w = 0;
      while ((sb0.size() != 0 || bus0.busy) && w < 9000) begin
        @(negedge clk);
        w++;
      end
      check("sweep_finished", (sb0.size() == 0 && !bus0.busy) ? 1 : 0, 1);
      repeat (5) @(negedge clk);
      check("hold_bidx", bus0.best_idx, vecs[i].x_idx);
      check("hold_lock", bus0.lock, vecs[i].x_lock);
    end

    // Abort at hyp 7 after a sweep that chose hyp 2.
    for (int k = 0; k < NH0; k++) etab0[k] = 20'd60000;
    start0(t0);
    dc = done_cnt0;
    w = 0;
    while (!(bus0.shift_parse && bus0.hyp_idx == 8'd7) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("reach_hyp7", bus0.hyp_idx, 7);
    repeat (20) @(negedge clk);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    check("abort_busy", bus0.busy, 0);
    check("abort_hyp", bus0.hyp_idx, 7);
    check("abort_bidx", bus0.best_idx, 2);
    check("abort_benergy", bus0.best_energy, 3000);
    check("abort_lock", bus0.lock, 0);
    repeat (1000) @(negedge clk);
    check("abort_no_done", done_cnt0, dc);
    check("abort_idle", bus0.busy, 0);

    w = 0;
    while (!fin1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check("dut1_finished", fin1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // SKIP_WIN=1: hyp 3 has a huge discard-window energy that must never be chosen.
  initial begin : main1
    int t0, w, last;
    logic [19:0] cv[NH1];
    cv[0] = 20'd1000; cv[1] = 20'd1400; cv[2] = 20'd1200; cv[3] = 20'd10;
    cv[4] = 20'd1300; cv[5] = 20'd1100; cv[6] = 20'd900;  cv[7] = 20'd800;
    for (int k = 0; k < NH1; k++) begin
      cap1[k]  = cv[k];
      disc1[k] = (k == 3) ? 20'd50000 : 20'd2000;
    end
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus1.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus1.start = 1'b0;
    last = 0;
    for (int k = 0; k < NH1; k++) begin
      w = 0;
      while (!bus1.shift_parse && w < 2000) begin
        @(negedge clk);
        w++;
      end
      check("s1_shift_seen", bus1.shift_parse, 1);
      check("s1_hyp", bus1.hyp_idx, k);
      if (k == 0) check("s1_first_shift", cyc, t0 + 1);
      else check("s1_period", cyc - last, PER1);
      last = cyc;
      @(negedge clk);
    end
    w = 0;
    while (!bus1.done && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("s1_done_cycle", cyc, t0 + PER1 * NH1 + 1);
    check("s1_best_idx", bus1.best_idx, 1);
    check("s1_best_energy", bus1.best_energy, 1400);
    check("s1_lock", bus1.lock, 0);
    fin1 = 1;
  end

endmodule
